subneg_mem_responder: RTL and testbench
=======================================

SUBNEG_MEM_RESPONDER -- requirements
Module: subneg_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of on-chip RAM bytes at addresses 0..DEPTH-1; legal range 2..254.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  reset; reset is synchronous and active-high on clk.
REQ-004 SHALL have port bus_in  in  8  multiplexed address/data from initiator.
REQ-005 SHALL have port le  in  1  address latch enable, active-high: transparent while 1, holds while 0.
REQ-006 SHALL have port oe_n  in  1  output enable, active-low.
REQ-007 SHALL have port we_n  in  1  write enable, active-low.
REQ-008 SHALL have port bus_out  out  8  read data to initiator.
REQ-009 SHALL have port bus_oe  out  1  drive enable for bus_out, active-high.
REQ-010 SHALL have port in_port  in  8  external byte readable at address 0xFE.
REQ-011 SHALL have port out_port  out  8  last byte written to address 0xFF.
REQ-012 SHALL have port out_valid  out  1  one-cycle pulse on each 0xFF write.
REQ-013 SHALL have port err  out  1  sticky protocol-violation flag.

Function
REQ-014 SHALL capture addr_q <= bus_in at every clk edge where le=1; addr_q SHALL hold at every edge where le=0.
REQ-015 SHALL drive bus_oe = (oe_n=0 and we_n=1) combinationally, with zero-cycle latency, so the initiator can sample in the same cycle it asserts oe_n.
REQ-016 SHALL drive bus_out combinationally from addr_q:
  - addr_q < DEPTH -> ram[addr_q]
  - 0xFE -> in_port
  - all other addresses -> 0x00
REQ-017 SHALL drive bus_out as 0x00 whenever bus_oe=0.
REQ-018 SHALL write bus_in to the location selected by addr_q at every edge where we_n=0 and le=0 (level write); repeated writes while we_n stays low are permitted and idempotent.
REQ-019 A write to addr_q < DEPTH SHALL update ram; a write to 0xFF SHALL load out_port and set out_valid=1 for exactly the next cycle; writes to any other address SHALL be discarded.
REQ-020 Write data SHALL be visible on bus_out at the first edge after the write edge (read-after-write latency 1 cycle).
REQ-021 When a read and a write are both requested (oe_n=0 and we_n=0), the write SHALL occur, bus_oe SHALL be 0, and err SHALL set.
REQ-022 When we_n=0 and le=1 at the same edge, the write SHALL be suppressed, addr_q SHALL still capture, and err SHALL set.
REQ-023 out_valid SHALL pulse once per edge with we_n=0 and addr_q=0xFF; a held we_n SHALL pulse on every such edge.
REQ-024 err SHALL be sticky and SHALL clear only on reset.

Reset
REQ-025 At a reset edge, the following SHALL be set: addr_q=0x00, out_port=0x00, out_valid=0, err=0.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 Any write requested at a reset edge SHALL be suppressed.
REQ-028 The combinational outputs bus_oe and bus_out SHALL follow REQ-015 to REQ-017 during reset.

Structure
REQ-029 Shared package subneg_bus_pkg SHALL hold:
  - BUS_W=8
  - ADDR_IN=8'hFE
  - ADDR_OUT=8'hFF
REQ-030 Sub-module subneg_ram SHALL implement the DEPTH x 8 synchronous-write, asynchronous-read array; address decode and strobe checking SHALL stay in the top level.

Verification
REQ-031 Latch then read: le=1 with bus_in=0x05 for one edge, le=0, ram[5] preloaded 0x3C, oe_n=0 -> same cycle bus_oe=1 and bus_out=0x3C.
REQ-032 Write then read back: latch 0x07, bus_in=0xA5 with we_n=0 for one edge, we_n=1, oe_n=0 -> bus_out=0xA5 and err=0.
REQ-033 Output port: latch 0xFF, bus_in=0x42 with we_n=0 for two edges -> out_port=0x42 and out_valid high for 2 cycles; then oe_n=0 -> bus_out=0x00.
REQ-034 Input port and unmapped read: in_port=0x9E, latch 0xFE, oe_n=0 -> bus_out=0x9E; latch 0x80 -> bus_out=0x00.
REQ-035 Violations: oe_n=0 and we_n=0 at address 3 with bus_in=0x11 -> ram[3]=0x11, bus_oe=0, err=1; then we_n=0 with le=1 -> no write; err stays 1 until reset.
REQ-036 Reset mid-write: we_n=0 at address 2 with reset=1 at the same edge -> ram[2] unchanged, addr_q=0x00, out_valid=0.

Source files
------------

// File: rtl/subneg_bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// subneg_bus_pkg : shared bus width and memory-mapped I/O addresses
// Revision 1.0
// ----------------------------------------------------------------------------
package subneg_bus_pkg;

  localparam int BUS_W = 8;

  typedef logic [BUS_W-1:0] bus_t;

  localparam bus_t ADDR_IN  = 8'hFE;
  localparam bus_t ADDR_OUT = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/subneg_mem_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// subneg_mem_responder_if : multiplexed address/data bus plus I/O port signals
// Revision 1.0
// ----------------------------------------------------------------------------
interface subneg_mem_responder_if;
  import subneg_bus_pkg::*;

  bus_t bus_in;
  logic le;
  logic oe_n;
  logic we_n;
  bus_t bus_out;
  logic bus_oe;
  bus_t in_port;
  bus_t out_port;
  logic out_valid;
  logic err;

  modport slave (
    input  bus_in, le, oe_n, we_n, in_port,
    output bus_out, bus_oe, out_port, out_valid, err
  );

  modport master (
    output bus_in, le, oe_n, we_n, in_port,
    input  bus_out, bus_oe, out_port, out_valid, err
  );

endinterface
`default_nettype wire

// File: rtl/subneg_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// subneg_ram : DEPTH x 8 array, synchronous write, asynchronous read
// Revision 1.0
// ----------------------------------------------------------------------------
module subneg_ram
  import subneg_bus_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  bus_t          i_wdata,
  input  logic [AW-1:0] i_raddr,
  output bus_t          o_rdata
);

  bus_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/subneg_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// subneg_mem_responder : latched-address byte memory with input/output ports
// Revision 1.0
// ----------------------------------------------------------------------------
module subneg_mem_responder
  import subneg_bus_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  subneg_mem_responder_if.slave  bus
);

  localparam int   c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bus_t c_DEPTH = bus_t'(DEPTH);

  bus_t r_addr_q;
  bus_t r_out_port;
  logic r_out_valid;
  logic r_err;

  logic w_in_ram;
  logic w_wr_req;
  logic w_ram_we;
  logic w_violation;
  bus_t w_ram_rdata;
  bus_t w_rd_data;
  logic w_bus_oe;

  assign w_in_ram    = (r_addr_q < c_DEPTH);
  // Level write: only while the address latch is closed and not in reset.
  assign w_wr_req    = !bus.we_n && !bus.le && !reset;
  assign w_ram_we    = w_wr_req && w_in_ram;
  assign w_violation = !bus.we_n && (!bus.oe_n || bus.le);

  subneg_ram #(
    .DEPTH (DEPTH),
    .AW    (c_AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_addr_q[c_AW-1:0]),
    .i_wdata (bus.bus_in),
    .i_raddr (r_addr_q[c_AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_rd_data = '0;
    if (w_in_ram) begin
      w_rd_data = w_ram_rdata;
    end else if (r_addr_q == ADDR_IN) begin
      w_rd_data = bus.in_port;
    end
  end

  assign w_bus_oe      = !bus.oe_n && bus.we_n;
  assign bus.bus_oe    = w_bus_oe;
  assign bus.bus_out   = w_bus_oe ? w_rd_data : '0;
  assign bus.out_port  = r_out_port;
  assign bus.out_valid = r_out_valid;
  assign bus.err       = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_q    <= '0;
      r_out_port  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (bus.le) begin
        r_addr_q <= bus.bus_in;
      end
      r_out_valid <= w_wr_req && (r_addr_q == ADDR_OUT);
      if (w_wr_req && (r_addr_q == ADDR_OUT)) begin
        r_out_port <= bus.bus_in;
      end
      if (w_violation) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_subneg_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_subneg_mem_responder : directed scenarios plus random traffic vs. a model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_subneg_mem_responder;
  import subneg_bus_pkg::*;

  localparam int DEPTH = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  subneg_mem_responder_if bus_if ();

  subneg_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: memory map as plain arrays with a "written" flag per byte
  logic [7:0] m_mem   [256];
  bit         m_known [256];
  logic [7:0] m_addr;
  logic [7:0] m_outp;
  logic       m_ov;
  logic       m_err;
  bit         m_init;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic l,
                      input logic oe, input logic we, input logic [7:0] inp);
    int         a;
    logic       exp_oe;
    logic [7:0] exp_data;
    bit         data_known;
    @(negedge clk);
    reset          = r;
    bus_if.bus_in  = d;
    bus_if.le      = l;
    bus_if.oe_n    = oe;
    bus_if.we_n    = we;
    bus_if.in_port = inp;
    #1;
    a          = int'(m_addr);
    exp_oe     = !oe && we;
    data_known = 1'b1;
    exp_data   = 8'h00;
    if (exp_oe) begin
      if (a < DEPTH) begin
        exp_data   = m_mem[a];
        data_known = m_known[a];
      end else if (a == 254) begin
        exp_data = inp;
      end
    end
    chk("bus_oe", {7'b0, bus_if.bus_oe}, {7'b0, exp_oe});
    if (m_init && data_known) chk("bus_out", bus_if.bus_out, exp_data);

    @(posedge clk);
    if (r) begin
      m_addr = 8'h00;
      m_outp = 8'h00;
      m_ov   = 1'b0;
      m_err  = 1'b0;
      m_init = 1'b1;
    end else begin
      m_ov = 1'b0;
      if (!we && !l) begin
        if (a < DEPTH) begin
          m_mem[a]   = d;
          m_known[a] = 1'b1;
        end else if (a == 255) begin
          m_outp = d;
          m_ov   = 1'b1;
        end
      end
      if (!we && (!oe || l)) m_err = 1'b1;
      if (l) m_addr = d;
    end
    #1;
    if (m_init) begin
      chk("out_port", bus_if.out_port, m_outp);
      chk("out_valid", {7'b0, bus_if.out_valid}, {7'b0, m_ov});
      chk("err", {7'b0, bus_if.err}, {7'b0, m_err});
    end
  endtask

  task automatic latch(input logic [7:0] a);
    step(1'b0, a, 1'b1, 1'b1, 1'b1, 8'h00);
  endtask

  initial begin
    logic [7:0] ra;
    int         sel;
    checks = 0;
    errors = 0;
    m_init = 1'b0;
    m_addr = 8'h00;
    m_outp = 8'h00;
    m_ov   = 1'b0;
    m_err  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = 8'h00;
      m_known[i] = 1'b0;
    end
    reset          = 1'b1;
    bus_if.bus_in  = 8'h00;
    bus_if.le      = 1'b0;
    bus_if.oe_n    = 1'b1;
    bus_if.we_n    = 1'b1;
    bus_if.in_port = 8'h00;

    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

    // Latch then read from a preloaded location
    latch(8'h05);
    step(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00);
    latch(8'h05);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

    // Write then read back
    latch(8'h07);
    step(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

    // Output port held write, then read of 0xFF returns zero
    latch(8'hFF);
    step(1'b0, 8'h42, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h42, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

    // Input port and unmapped read
    latch(8'hFE);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h9E);
    latch(8'h80);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h9E);

    // Read/write collision, then write with latch open
    latch(8'h03);
    step(1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);

    // Reset coinciding with a write
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    latch(8'h02);
    step(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    latch(8'h02);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

    // Random traffic, biased toward RAM edges and the I/O addresses
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       ra = 8'hFE;
        1:       ra = 8'hFF;
        2:       ra = 8'(DEPTH - 1);
        3:       ra = 8'(DEPTH);
        4:       ra = 8'($urandom_range(0, 255));
        default: ra = 8'($urandom_range(0, DEPTH - 1));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, ra, 1'b1, 1'($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 7) != 0), 8'($urandom));
      end else begin
        step(($urandom_range(0, 99) == 0), 8'($urandom), 1'b0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'($urandom_range(0, 5) == 0),
             8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
